text_console_writer: RTL and testbench

Character-stream front end for the HDMI text display: consumes one byte per handshake from the CPU side and turns it into display-buffer writes on the `wen`/`write_addr`/`write_data` port the HDMI text renderer exposes. Maintains a cursor and interprets control codes: newline, carriage return, backspace, tab and form-feed. Clears lines and the screen by issuing fill writes. Sits between the CPU MMIO console register and the display buffer, in the `clk` (system) domain.

---
 rtl/text_console_writer_pkg.sv | 23 ++
 rtl/text_console_writer.sv | 185 ++++++++++++++++++
 tb/tb_text_console_writer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_writer_pkg.sv
// Shared console constants, control codes and the writer state type.
`default_nettype none

package text_console_writer_pkg;

  localparam int CONSOLE_COLS = 80;
  localparam int CONSOLE_ROWS = 25;

  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_FF  = 8'h0C;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_LINE   = 2'd1,
    CLR_SCREEN = 2'd2
  } console_state_t;

endpackage

`default_nettype wire

// File: rtl/text_console_writer.sv
// Byte-stream console: tracks a cursor, interprets control codes and emits
// display-buffer writes, including line and screen fills.
`default_nettype none

module text_console_writer
  import text_console_writer_pkg::*;
#(
  parameter int         COLS      = CONSOLE_COLS,
  parameter int         ROWS      = CONSOLE_ROWS,
  parameter logic [7:0] FILL_CHAR = 8'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        wen,
  output logic [10:0] write_addr,
  output logic [7:0]  write_data,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  if (COLS * ROWS > 2048) begin : g_size_check
    $error("text_console_writer: COLS*ROWS must not exceed 2048");
  end
  if (COLS > 128 || ROWS > 32) begin : g_dim_check
    $error("text_console_writer: COLS must be <= 128 and ROWS <= 32");
  end

  localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW     = 5'(ROWS - 1);
  localparam logic [10:0] LAST_COL_IDX = 11'(COLS - 1);
  localparam logic [10:0] LAST_ADDR    = 11'(COLS * ROWS - 1);
  localparam logic [10:0] COLS_W       = 11'(COLS);
  localparam logic [7:0]  COLS_B       = 8'(COLS);

  console_state_t state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [10:0] line_base_q, line_base_d;
  logic [10:0] clr_idx_q, clr_idx_d;
  logic        wen_q, wen_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  logic [4:0]  row_adv;
  logic [10:0] line_base_adv;
  logic [7:0]  tab_col;
  logic        tab_ovf;
  logic [10:0] glyph_addr;
  logic [10:0] clr_next;
  logic        accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      line_base_q <= '0;
      clr_idx_q   <= '0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      line_base_q <= line_base_d;
      clr_idx_q   <= clr_idx_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  // Row advance wraps to the top instead of scrolling.
  assign row_adv       = (row_q == LAST_ROW) ? 5'd0  : row_q + 5'd1;
  assign line_base_adv = (row_q == LAST_ROW) ? 11'd0 : line_base_q + COLS_W;
  assign tab_col       = {1'b0, col_q | 7'd7} + 8'd1;
  assign tab_ovf       = (tab_col >= COLS_B);
  assign glyph_addr    = line_base_q + {4'b0, col_q};
  assign clr_next      = clr_idx_q + 11'd1;
  assign accept        = char_valid && (state_q == IDLE);

  // Each fill write is registered one cycle ahead of the counter that
  // tracks it, so clr_idx names the write currently on the port. A wrap
  // entry preloads all-ones so the cycle showing the glyph issues index 0.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    line_base_d = line_base_q;
    clr_idx_d   = clr_idx_q;
    wen_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (char_data == ASCII_LF || (char_data == ASCII_TAB && tab_ovf)) begin
            col_d       = '0;
            row_d       = row_adv;
            line_base_d = line_base_adv;
            state_d     = CLR_LINE;
            clr_idx_d   = '0;
            wen_d       = 1'b1;
            addr_d      = line_base_adv;
            data_d      = FILL_CHAR;
          end else if (char_data == ASCII_TAB) begin
            col_d = tab_col[6:0];
          end else if (char_data == ASCII_CR) begin
            col_d = '0;
          end else if (char_data == ASCII_BS) begin
            if (col_q != 7'd0) begin
              col_d  = col_q - 7'd1;
              wen_d  = 1'b1;
              addr_d = glyph_addr - 11'd1;
              data_d = FILL_CHAR;
            end
          end else if (char_data == ASCII_FF) begin
            col_d       = '0;
            row_d       = '0;
            line_base_d = '0;
            state_d     = CLR_SCREEN;
            clr_idx_d   = '0;
            wen_d       = 1'b1;
            addr_d      = '0;
            data_d      = FILL_CHAR;
          end else begin
            wen_d  = 1'b1;
            addr_d = glyph_addr;
            data_d = char_data;
            if (col_q == LAST_COL) begin
              col_d       = '0;
              row_d       = row_adv;
              line_base_d = line_base_adv;
              state_d     = CLR_LINE;
              clr_idx_d   = '1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end
        end
      end

      CLR_LINE: begin
        if (clr_idx_q == LAST_COL_IDX) begin
          state_d = IDLE;
        end else begin
          clr_idx_d = clr_next;
          wen_d     = 1'b1;
          addr_d    = line_base_q + clr_next;
          data_d    = FILL_CHAR;
        end
      end

      CLR_SCREEN: begin
        if (clr_idx_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          clr_idx_d = clr_next;
          wen_d     = 1'b1;
          addr_d    = clr_next;
          data_d    = FILL_CHAR;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign char_ready = (state_q == IDLE);
  assign busy       = ~char_ready;
  assign wen        = wen_q;
  assign write_addr = addr_q;
  assign write_data = data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

`default_nettype wire

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer (80x25).
`default_nettype none

module tb_text_console_writer;

  logic        clk;
  logic        resetn;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        wen;
  logic [10:0] write_addr;
  logic [7:0]  write_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  text_console_writer #(.COLS(80), .ROWS(25), .FILL_CHAR(8'h00)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .wen        (wen),
    .write_addr (write_addr),
    .write_data (write_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!char_ready && n < 5000) begin
      tick();
      n++;
    end
    if (!char_ready) check("ready_timeout", 0, 1);
  endtask

  // Presents one byte and returns at the sample point right after acceptance.
  task automatic send(input logic [7:0] b);
    wait_ready();
    char_valid = 1'b1;
    char_data  = b;
    tick();
    char_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int low;

    resetn     = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    check("rst_wen",   int'(wen), 0);
    check("rst_addr",  int'(write_addr), 0);
    check("rst_data",  int'(write_data), 0);
    check("rst_ready", int'(char_ready), 1);
    check("rst_busy",  int'(busy), 0);
    check("rst_col",   int'(cursor_col), 0);
    check("rst_row",   int'(cursor_row), 0);

    // "Hi" back-to-back
    char_valid = 1'b1;
    char_data  = "H";
    tick();
    check("H_wen",   int'(wen), 1);
    check("H_addr",  int'(write_addr), 0);
    check("H_data",  int'(write_data), 8'h48);
    check("H_ready", int'(char_ready), 1);
    char_data = "i";
    tick();
    check("i_wen",   int'(wen), 1);
    check("i_addr",  int'(write_addr), 1);
    check("i_data",  int'(write_data), 8'h69);
    check("i_ready", int'(char_ready), 1);
    char_valid = 1'b0;
    tick();
    check("hi_wen_idle", int'(wen), 0);
    check("hi_col", int'(cursor_col), 2);
    check("hi_row", int'(cursor_row), 0);

    // LF from column 3: clear row 1 (80..159)
    send("X");
    check("x_col", int'(cursor_col), 3);
    send(8'h0A);
    bad = 0;
    low = 0;
    for (int i = 0; i < 80; i++) begin
      if (!(wen && write_addr == 11'(80 + i) && write_data == 8'h00)) bad++;
      if (!char_ready) low++;
      tick();
    end
    check("lf_clear_writes", bad, 0);
    check("lf_ready_low", low, 80);
    check("lf_ready_after", int'(char_ready), 1);
    check("lf_wen_after", int'(wen), 0);
    check("lf_col", int'(cursor_col), 0);
    check("lf_row", int'(cursor_row), 1);

    // Fill row 24 to force a wrap to the top
    repeat (23) send(8'h0A);
    wait_ready();
    check("r24_row", int'(cursor_row), 24);
    repeat (79) send("g");
    check("r24_col79", int'(cursor_col), 79);
    send("Z");
    check("wrap_glyph_wen",   int'(wen), 1);
    check("wrap_glyph_addr",  int'(write_addr), 1999);
    check("wrap_glyph_data",  int'(write_data), 8'h5A);
    check("wrap_glyph_ready", int'(char_ready), 0);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (!(wen && write_addr == 11'(i) && write_data == 8'h00 && !char_ready)) bad++;
    end
    check("wrap_clear_writes", bad, 0);
    tick();
    check("wrap_ready", int'(char_ready), 1);
    check("wrap_wen_after", int'(wen), 0);
    check("wrap_col", int'(cursor_col), 0);
    check("wrap_row", int'(cursor_row), 0);

    // Backspace on row 5
    repeat (5) send(8'h0A);
    wait_ready();
    send(8'h08);
    check("bs0_wen", int'(wen), 0);
    check("bs0_col", int'(cursor_col), 0);
    check("bs0_row", int'(cursor_row), 5);
    repeat (10) send("a");
    send(8'h08);
    check("bs10_wen",  int'(wen), 1);
    check("bs10_addr", int'(write_addr), 409);
    check("bs10_data", int'(write_data), 0);
    check("bs10_col",  int'(cursor_col), 9);
    check("bs10_row",  int'(cursor_row), 5);

    // CR and TAB
    send(8'h0D);
    check("cr_wen", int'(wen), 0);
    check("cr_col", int'(cursor_col), 0);
    repeat (3) send("b");
    send(8'h09);
    check("tab3_wen", int'(wen), 0);
    check("tab3_col", int'(cursor_col), 8);
    check("tab3_ready", int'(char_ready), 1);
    send(8'h0D);
    repeat (77) send("c");
    check("tab77_pre_col", int'(cursor_col), 77);
    send(8'h09);
    check("tab77_wen",   int'(wen), 1);
    check("tab77_addr",  int'(write_addr), 480);
    check("tab77_ready", int'(char_ready), 0);
    check("tab77_col",   int'(cursor_col), 0);
    check("tab77_row",   int'(cursor_row), 6);
    wait_ready();
    check("tab77_wen_after", int'(wen), 0);

    // Full-screen clear
    send(8'h0C);
    bad = 0;
    low = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!(wen && write_addr == 11'(i) && write_data == 8'h00)) bad++;
      if (!char_ready) low++;
      tick();
    end
    check("ff_writes", bad, 0);
    check("ff_ready_low", low, 2000);
    check("ff_ready_after", int'(char_ready), 1);
    check("ff_wen_after", int'(wen), 0);
    check("ff_col", int'(cursor_col), 0);
    check("ff_row", int'(cursor_row), 0);

    // Reset in the middle of a screen clear
    send("q");
    send(8'h0C);
    repeat (699) tick();
    check("ff700_addr", int'(write_addr), 699);
    check("ff700_wen", int'(wen), 1);
    resetn = 1'b0;
    #1;
    check("abort_wen",   int'(wen), 0);
    check("abort_addr",  int'(write_addr), 0);
    check("abort_ready", int'(char_ready), 1);
    check("abort_col",   int'(cursor_col), 0);
    check("abort_row",   int'(cursor_row), 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("post_ready", int'(char_ready), 1);
    check("post_wen",   int'(wen), 0);
    send("k");
    check("post_glyph_addr", int'(write_addr), 0);
    check("post_glyph_col",  int'(cursor_col), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
